store_commit_queue: RTL and testbench
=====================================

Name: store_commit_queue

Overview:
- Circular store queue that sits between dispatch/AGU and the data-memory write port, and consumes the ROB's commit_store_ids / commit_store_vals.
- Allocates one entry per dispatched store and captures address/data from the store AGU writeback.
- Marks entries committed when the ROB retires them, then drains committed stores to memory in program order over a valid/ready handshake.
- On flush, keeps committed stores and discards speculative ones.

Parameters:
- SQ_ENTRIES, 8, queue depth (power of two, ≥4).
- ROB_TAG_BITS, $clog2(ROB_ENTRIES), width of ROB tags.
- PIPE_WIDTH, 2, allocation and commit ports per cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  pipeline flush from commit.
- sq_alloc_req  in  PIPE_WIDTH  per-slot store allocation request.
- sq_alloc_tags  in  PIPE_WIDTH×ROB_TAG_BITS  ROB tag of each requesting store.
- sq_alloc_gnt  out  PIPE_WIDTH  allocation grant (combinational).
- st_wb_valid  in  1  store AGU result valid.
- st_wb_tag  in  ROB_TAG_BITS  ROB tag of the executed store.
- st_wb_addr  in  32  effective address.
- st_wb_data  in  32  unaligned store data, in the low bytes.
- st_wb_size  in  2  access size: 00 byte, 01 half, 10 word.
- commit_store_vals  in  PIPE_WIDTH  commit valid per port.
- commit_store_ids  in  PIPE_WIDTH×ROB_TAG_BITS  committed store ROB tag.
- dmem_req_valid  out  1  write request valid.
- dmem_req_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- dmem_req_data  out  32  lane-aligned data.
- dmem_req_wstrb  out  4  byte strobes.
- dmem_req_ready  in  1  memory accepts request.
- sq_count  out  $clog2(SQ_ENTRIES)+1  occupied entries.
- sq_empty  out  1  sq_count==0.

Behaviour:
- **Reset:** when rst is high at a clk edge, head=tail=0, count=0, and all entries are cleared.
  - After reset: dmem_req_valid=0, addr/data/wstrb=0, sq_count=0, sq_empty=1.
  - sq_alloc_gnt is forced to 0 while rst is high.
- **Entry fields:** valid, rob_tag, addr_rdy, addr, data, size, committed.
- **Allocation** (all-or-nothing):
  - req_cnt = popcount(sq_alloc_req).
  - gnt[i] = req[i] && free ≥ req_cnt && !flush.
  - Granted slot 0 writes at tail; slot 1 writes at tail (if only req[1] is set) or tail+1 (if both are set).
  - New entries start with addr_rdy=0, committed=0.
  - tail advances by the grant count; tail wraps modulo SQ_ENTRIES.
- **Writeback:** when st_wb_valid is set, every valid entry with rob_tag==st_wb_tag captures addr, data and size, and sets addr_rdy.
  - Writeback in the same cycle as allocation of that tag is not required; it is an upstream guarantee not to happen.
- **Commit:** for each port p with commit_store_vals[p] set, the valid entry whose rob_tag matches commit_store_ids[p] sets committed.
  - Both ports may hit in the same cycle.
  - A commit may arrive before addr_rdy; the entry then waits.
- **Drain:**
  - dmem_req_valid = head.valid && head.committed && head.addr_rdy. Outputs are combinational from the head entry.
  - wstrb by size: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
  - dmem_req_data = st_wb_data << (8*addr[1:0]).
  - While valid && !ready, the request fields hold stable (head does not change).
  - On valid && ready: the head entry is cleared, head+1, count-1.
  - Throughput: one store per cycle.
- **Flush:**
  - At the clk edge with flush=1, all entries with committed==0 are invalidated.
  - tail = head + (number of committed entries). Committed entries are contiguous from head because commit is in order.
  - Commits presented in the flush cycle are applied first, so they survive the flush.
  - A drain handshake in the flush cycle also completes (head pops).
  - No allocation occurs in the flush cycle.
- **Count:** count_next = count + alloc_cnt − pop (or the committed-survivor count on flush).
  - Full when count==SQ_ENTRIES: every request is denied.
  - Empty: dmem_req_valid=0.
- **Simultaneous events:** alloc, writeback, commit and drain in one cycle are all legal. An entry popped this cycle cannot be re-allocated until the next cycle.
- **Reset mid-operation:** a pending request is dropped, valid deasserts the next cycle, and the memory side must tolerate this.

Test Plan:
- Reset, then alloc tags {3,4} → gnt=2'b11, sq_count=2. WB tag3 addr 0x1002 data 0xAB size 00. Commit tag3 → dmem_req_valid=1, addr=0x1000, wstrb=4'b0100, data=0x00AB0000.
- Hold dmem_req_ready=0 for 3 cycles → addr/data/wstrb stable and valid held. Ready=1 → pop, sq_count decrements by 1.
- Commit tag5 before its WB → no request. WB on the next cycle with addr 0x2000, size 10, data 0xDEADBEEF → request the following cycle with wstrb=4'b1111.
- Fill 8 entries → sq_alloc_gnt=0. With 7 entries, request 2 → both denied (all-or-nothing); request 1 → granted.
- Six entries, two committed, flush with a third commit in the same cycle → sq_count=3, tail=head+3, and the three drain in order.
- Tail wrap: allocate/drain 20 stores → tags emerge in allocation order across the index 7→0 boundary.

Source files
------------

// File: rtl/store_commit_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// store_commit_queue : circular store queue, in-order drain of committed stores
// Revision: 1.0
// ---------------------------------------------------------------------------
module store_commit_queue #(
  parameter int SQ_ENTRIES   = 8,
  parameter int ROB_ENTRIES  = 32,
  parameter int ROB_TAG_BITS = $clog2(ROB_ENTRIES),
  parameter int PIPE_WIDTH   = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [PIPE_WIDTH-1:0]              sq_alloc_req,
  input  logic [PIPE_WIDTH*ROB_TAG_BITS-1:0] sq_alloc_tags,
  output logic [PIPE_WIDTH-1:0]              sq_alloc_gnt,
  input  logic                               st_wb_valid,
  input  logic [ROB_TAG_BITS-1:0]            st_wb_tag,
  input  logic [31:0]                        st_wb_addr,
  input  logic [31:0]                        st_wb_data,
  input  logic [1:0]                         st_wb_size,
  input  logic [PIPE_WIDTH-1:0]              commit_store_vals,
  input  logic [PIPE_WIDTH*ROB_TAG_BITS-1:0] commit_store_ids,
  output logic                               dmem_req_valid,
  output logic [31:0]                        dmem_req_addr,
  output logic [31:0]                        dmem_req_data,
  output logic [3:0]                         dmem_req_wstrb,
  input  logic                               dmem_req_ready,
  output logic [$clog2(SQ_ENTRIES):0]        sq_count,
  output logic                               sq_empty
);
  localparam int IDX = $clog2(SQ_ENTRIES);
  localparam int CW  = IDX + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(SQ_ENTRIES);

  logic [SQ_ENTRIES-1:0]   ent_valid;
  logic [SQ_ENTRIES-1:0]   ent_addr_rdy;
  logic [SQ_ENTRIES-1:0]   ent_committed;
  logic [ROB_TAG_BITS-1:0] ent_tag  [SQ_ENTRIES];
  logic [31:0]             ent_addr [SQ_ENTRIES];
  logic [31:0]             ent_data [SQ_ENTRIES];
  logic [1:0]              ent_size [SQ_ENTRIES];

  logic [IDX-1:0] head;
  logic [IDX-1:0] tail;
  logic [CW-1:0]  count;

  logic [CW-1:0]         req_cnt;
  logic [CW-1:0]         alloc_cnt;
  logic                  alloc_ok;
  logic [IDX-1:0]        alloc_idx [PIPE_WIDTH];
  logic [SQ_ENTRIES-1:0] committed_nxt;
  logic [CW-1:0]         survivors;
  logic                  pop;

  // All-or-nothing: a partial grant would split a dispatch group.
  always_comb begin
    req_cnt = '0;
    for (int i = 0; i < PIPE_WIDTH; i++) begin
      req_cnt = req_cnt + CW'(sq_alloc_req[i]);
    end
    alloc_ok     = ((C_DEPTH - count) >= req_cnt) && !flush && !rst;
    sq_alloc_gnt = alloc_ok ? sq_alloc_req : '0;
    alloc_cnt    = alloc_ok ? req_cnt : '0;
  end

  always_comb begin : p_alloc_idx
    logic [IDX-1:0] ofs;
    ofs = tail;
    for (int i = 0; i < PIPE_WIDTH; i++) begin
      alloc_idx[i] = ofs;
      if (sq_alloc_req[i]) ofs = ofs + 1'b1;
    end
  end

  // Commits of this cycle are folded in first so they survive a same-cycle flush.
  always_comb begin
    survivors = '0;
    for (int e = 0; e < SQ_ENTRIES; e++) begin
      committed_nxt[e] = ent_committed[e];
      for (int p = 0; p < PIPE_WIDTH; p++) begin
        if (commit_store_vals[p] && ent_valid[e] &&
            ent_tag[e] == commit_store_ids[p*ROB_TAG_BITS +: ROB_TAG_BITS]) begin
          committed_nxt[e] = 1'b1;
        end
      end
      survivors = survivors + CW'(ent_valid[e] && committed_nxt[e]);
    end
  end

  always_comb begin
    dmem_req_valid = ent_valid[head] && ent_committed[head] && ent_addr_rdy[head];
    dmem_req_addr  = '0;
    dmem_req_data  = '0;
    dmem_req_wstrb = '0;
    if (dmem_req_valid) begin
      dmem_req_addr = {ent_addr[head][31:2], 2'b00};
      dmem_req_data = ent_data[head] << {ent_addr[head][1:0], 3'b000};
      case (ent_size[head])
        2'b00:   dmem_req_wstrb = 4'b0001 << ent_addr[head][1:0];
        2'b01:   dmem_req_wstrb = 4'b0011 << ent_addr[head][1:0];
        default: dmem_req_wstrb = 4'b1111;
      endcase
    end
  end

  assign pop      = dmem_req_valid && dmem_req_ready;
  assign sq_count = count;
  assign sq_empty = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int e = 0; e < SQ_ENTRIES; e++) begin
        ent_valid[e]     <= 1'b0;
        ent_addr_rdy[e]  <= 1'b0;
        ent_committed[e] <= 1'b0;
        ent_tag[e]       <= '0;
        ent_addr[e]      <= '0;
        ent_data[e]      <= '0;
        ent_size[e]      <= '0;
      end
    end else begin
      for (int e = 0; e < SQ_ENTRIES; e++) begin
        if (st_wb_valid && ent_valid[e] && ent_tag[e] == st_wb_tag) begin
          ent_addr[e]     <= st_wb_addr;
          ent_data[e]     <= st_wb_data;
          ent_size[e]     <= st_wb_size;
          ent_addr_rdy[e] <= 1'b1;
        end
        ent_committed[e] <= committed_nxt[e];
        if (flush && !committed_nxt[e]) ent_valid[e] <= 1'b0;
      end
      if (pop) begin
        ent_valid[head]     <= 1'b0;
        ent_committed[head] <= 1'b0;
        ent_addr_rdy[head]  <= 1'b0;
      end
      // Allocation targets only free slots, so it never collides with the updates above.
      for (int i = 0; i < PIPE_WIDTH; i++) begin
        if (sq_alloc_gnt[i]) begin
          ent_valid[alloc_idx[i]]     <= 1'b1;
          ent_tag[alloc_idx[i]]       <= sq_alloc_tags[i*ROB_TAG_BITS +: ROB_TAG_BITS];
          ent_addr_rdy[alloc_idx[i]]  <= 1'b0;
          ent_committed[alloc_idx[i]] <= 1'b0;
        end
      end
      head <= head + IDX'(pop);
      if (flush) begin
        tail  <= head + survivors[IDX-1:0];
        count <= survivors - CW'(pop);
      end else begin
        tail  <= tail + alloc_cnt[IDX-1:0];
        count <= count + alloc_cnt - CW'(pop);
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_store_commit_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_store_commit_queue : directed + random scoreboard bench for the store queue
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_store_commit_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [1:0]  sq_alloc_req = '0;
  logic [9:0]  sq_alloc_tags = '0;
  logic [1:0]  sq_alloc_gnt;
  logic        st_wb_valid = 1'b0;
  logic [4:0]  st_wb_tag = '0;
  logic [31:0] st_wb_addr = '0;
  logic [31:0] st_wb_data = '0;
  logic [1:0]  st_wb_size = '0;
  logic [1:0]  commit_store_vals = '0;
  logic [9:0]  commit_store_ids = '0;
  logic        dmem_req_valid;
  logic [31:0] dmem_req_addr;
  logic [31:0] dmem_req_data;
  logic [3:0]  dmem_req_wstrb;
  logic        dmem_req_ready = 1'b0;
  logic [3:0]  sq_count;
  logic        sq_empty;

  store_commit_queue #(.SQ_ENTRIES(8), .ROB_ENTRIES(32), .PIPE_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .sq_alloc_req(sq_alloc_req), .sq_alloc_tags(sq_alloc_tags), .sq_alloc_gnt(sq_alloc_gnt),
    .st_wb_valid(st_wb_valid), .st_wb_tag(st_wb_tag), .st_wb_addr(st_wb_addr),
    .st_wb_data(st_wb_data), .st_wb_size(st_wb_size),
    .commit_store_vals(commit_store_vals), .commit_store_ids(commit_store_ids),
    .dmem_req_valid(dmem_req_valid), .dmem_req_addr(dmem_req_addr),
    .dmem_req_data(dmem_req_data), .dmem_req_wstrb(dmem_req_wstrb),
    .dmem_req_ready(dmem_req_ready), .sq_count(sq_count), .sq_empty(sq_empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [4:0] tag; logic wb; logic cm;} ent_t;
  ent_t        mq[$];     // reference queue, oldest first
  logic [4:0]  expq[$];   // committed tags, in the order they must reach memory
  logic [31:0] wa_m [32];
  logic [31:0] wd_m [32];
  logic [1:0]  ws_m [32];
  logic [1:0]  last_gnt;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [3:0] strb_of(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'd0:    return 4'b0001 << off;
      2'd1:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // One clock of stimulus; checks the pre-edge state, then advances the model.
  task automatic step(input logic [1:0] req, input logic [4:0] t0, input logic [4:0] t1,
                      input logic wbv, input logic [4:0] wbt, input logic [31:0] wa,
                      input logic [31:0] wd, input logic [1:0] ws,
                      input logic [1:0] cv, input logic [4:0] c0, input logic [4:0] c1,
                      input logic fl, input logic rdy);
    logic [1:0] exp_gnt;
    logic       pre_valid;
    int         rc;
    ent_t       keep[$];
    @(negedge clk);
    sq_alloc_req = req; sq_alloc_tags = {t1, t0};
    st_wb_valid = wbv; st_wb_tag = wbt; st_wb_addr = wa; st_wb_data = wd; st_wb_size = ws;
    commit_store_vals = cv; commit_store_ids = {c1, c0};
    flush = fl; dmem_req_ready = rdy;
    #1;
    rc = int'(req[0]) + int'(req[1]);
    exp_gnt = (rc <= 8 - mq.size() && !fl) ? req : 2'b00;
    pre_valid = mq.size() > 0 && mq[0].cm && mq[0].wb;
    chk("alloc_gnt", sq_alloc_gnt, exp_gnt);
    chk("sq_count", sq_count, mq.size());
    chk("sq_empty", sq_empty, mq.size() == 0);
    chk("req_valid", dmem_req_valid, pre_valid);
    @(posedge clk);
    if (wbv) begin
      foreach (mq[i]) if (mq[i].tag == wbt) mq[i].wb = 1'b1;
      wa_m[wbt] = wa; wd_m[wbt] = wd; ws_m[wbt] = ws;
    end
    for (int p = 0; p < 2; p++) begin
      if (cv[p]) begin
        foreach (mq[i]) begin
          if (mq[i].tag == (p == 0 ? c0 : c1)) begin
            mq[i].cm = 1'b1;
            expq.push_back(mq[i].tag);
          end
        end
      end
    end
    if (pre_valid && rdy) void'(mq.pop_front());
    if (fl) begin
      foreach (mq[i]) if (mq[i].cm) keep.push_back(mq[i]);
      mq = keep;
    end
    if (exp_gnt[0]) mq.push_back('{tag: t0, wb: 1'b0, cm: 1'b0});
    if (exp_gnt[1]) mq.push_back('{tag: t1, wb: 1'b0, cm: 1'b0});
    last_gnt = exp_gnt;
  endtask

  task automatic idle(input logic rdy);
    step(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 32'd0, 2'd0, 2'b00, 5'd0, 5'd0, 1'b0, rdy);
  endtask

  // Monitor: every accepted memory write is matched against the next committed store.
  initial begin
    logic [4:0] t;
    forever begin
      @(negedge clk);
      #2;
      if (rst === 1'b0 && dmem_req_valid && dmem_req_ready) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL drain_unexpected got addr %h expected no request", dmem_req_addr);
        end else begin
          t = expq.pop_front();
          chk("drain_addr", dmem_req_addr, wa_m[t] & 32'hFFFF_FFFC);
          chk("drain_data", dmem_req_data, wd_m[t] << (8 * wa_m[t][1:0]));
          chk("drain_wstrb", {28'd0, dmem_req_wstrb}, {28'd0, strb_of(ws_m[t], wa_m[t][1:0])});
        end
      end
    end
  end

  initial begin
    logic [4:0]  next_tag;
    logic [1:0]  req, cv;
    logic [4:0]  c0, c1, wbt;
    logic        wbv;
    int          u, k, cand[$];
    repeat (2) @(posedge clk);
    @(negedge clk);
    sq_alloc_req = 2'b11;
    #1 chk("gnt_in_reset", sq_alloc_gnt, 2'b00);
    @(negedge clk);
    sq_alloc_req = 2'b00; rst = 1'b0;
    #1;
    chk("rst_count", sq_count, 0);
    chk("rst_empty", sq_empty, 1);
    chk("rst_valid", dmem_req_valid, 0);
    chk("rst_addr", dmem_req_addr, 0);
    chk("rst_wstrb", dmem_req_wstrb, 0);

    // Byte store, back-pressure, then pop.
    step(2'b11, 5'd3, 5'd4, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    #3 chk("alloc2_count", sq_count, 2);
    step(2'b00, 0, 0, 1, 5'd3, 32'h1002, 32'hAB, 2'd0, 2'b00, 0, 0, 0, 0);
    step(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 5'd3, 0, 0, 0);
    #3;
    chk("byte_valid", dmem_req_valid, 1);
    chk("byte_addr", dmem_req_addr, 32'h1000);
    chk("byte_wstrb", dmem_req_wstrb, 4'b0100);
    chk("byte_data", dmem_req_data, 32'h00AB_0000);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      #3;
      chk("hold_valid", dmem_req_valid, 1);
      chk("hold_addr", dmem_req_addr, 32'h1000);
      chk("hold_data", dmem_req_data, 32'h00AB_0000);
      chk("hold_wstrb", dmem_req_wstrb, 4'b0100);
    end
    idle(1'b1);
    #3 chk("pop_count", sq_count, 1);

    // Half store drains; younger store committed ahead of its address waits.
    step(2'b01, 5'd5, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    step(2'b00, 0, 0, 1, 5'd4, 32'h3001, 32'h1234, 2'd1, 2'b00, 0, 0, 0, 0);
    step(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b11, 5'd4, 5'd5, 0, 0);
    idle(1'b1);
    #3 chk("no_req_before_wb", dmem_req_valid, 0);
    step(2'b00, 0, 0, 1, 5'd5, 32'h2000, 32'hDEADBEEF, 2'd2, 2'b00, 0, 0, 0, 0);
    #3;
    chk("word_valid", dmem_req_valid, 1);
    chk("word_wstrb", dmem_req_wstrb, 4'b1111);
    chk("word_data", dmem_req_data, 32'hDEADBEEF);
    idle(1'b1);

    // Full / near-full all-or-nothing allocation.
    step(2'b11, 5'd8, 5'd9, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    step(2'b11, 5'd10, 5'd11, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    step(2'b11, 5'd12, 5'd13, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    step(2'b01, 5'd14, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    step(2'b11, 5'd15, 5'd16, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    step(2'b01, 5'd15, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    step(2'b10, 0, 5'd16, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    #3 chk("full_count", sq_count, 8);
    step(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
    #3 chk("flush_all_count", sq_count, 0);

    // Flush with two committed plus a same-cycle commit.
    step(2'b11, 5'd16, 5'd17, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    step(2'b11, 5'd18, 5'd19, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    step(2'b11, 5'd20, 5'd21, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    for (int i = 16; i < 19; i++)
      step(2'b00, 0, 0, 1, 5'(i), 32'h100 + 32'(i * 5), $urandom, 2'(i % 3), 2'b00, 0, 0, 0, 0);
    step(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b11, 5'd16, 5'd17, 0, 0);
    step(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 5'd18, 0, 1, 0);
    #3 chk("flush_keep_count", sq_count, 3);
    repeat (4) idle(1'b1);
    #3 chk("flush_drained", sq_empty, 1);

    // Randomized traffic.
    next_tag = 5'd22;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      req = 2'($urandom_range(0, 3));
      cand.delete();
      foreach (mq[i]) if (!mq[i].wb) cand.push_back(i);
      wbv = (cand.size() > 0) && ($urandom_range(0, 9) < 7);
      wbt = wbv ? mq[cand[$urandom_range(0, cand.size() - 1)]].tag : 5'd0;
      u = 0;
      while (u < mq.size() && mq[u].cm) u++;
      k = $urandom_range(0, 2);
      if (k > mq.size() - u) k = mq.size() - u;
      cv = 2'b00; c0 = '0; c1 = '0;
      if (k == 2) begin
        cv = 2'b11; c0 = mq[u].tag; c1 = mq[u + 1].tag;
      end else if (k == 1) begin
        if ($urandom_range(0, 1) == 0) begin cv = 2'b01; c0 = mq[u].tag; end
        else begin cv = 2'b10; c1 = mq[u].tag; end
      end
      step(req, next_tag, next_tag + 5'(req[0]), wbv, wbt, $urandom, $urandom,
           2'($urandom_range(0, 2)), cv, c0, c1, $urandom_range(0, 29) == 0,
           $urandom_range(0, 9) < 7);
      next_tag = next_tag + 5'(last_gnt[0]) + 5'(last_gnt[1]);
    end

    // Drain everything left, bounded.
    for (int cyc = 0; cyc < 100 && mq.size() > 0; cyc++) begin
      wbv = 1'b0; wbt = '0;
      foreach (mq[i]) if (!wbv && !mq[i].wb) begin wbv = 1'b1; wbt = mq[i].tag; end
      u = 0;
      while (u < mq.size() && mq[u].cm) u++;
      cv = 2'b00; c0 = '0; c1 = '0;
      if (mq.size() - u >= 2) begin cv = 2'b11; c0 = mq[u].tag; c1 = mq[u + 1].tag; end
      else if (mq.size() - u == 1) begin cv = 2'b01; c0 = mq[u].tag; end
      step(2'b00, 0, 0, wbv, wbt, $urandom, $urandom, 2'($urandom_range(0, 2)),
           cv, c0, c1, 0, 1);
    end
    idle(1'b1);
    #3;
    chk("final_empty", sq_empty, 1);
    chk("scoreboard_empty", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
